// File: rtl/cfw_pkg.sv
// cfw_pkg: shared FSM state type, default geometry and buffer base addresses for capture_frame_writer
package cfw_pkg;

    typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, FLUSH} cfw_state_e;

    localparam int PIX_PER_WORD = 64 / 8;
    localparam int BURSTS_PER_FRAME = 307200 / (PIX_PER_WORD * 16);
    localparam logic [27:0] BASE0_DEFAULT = 28'h000_0000;
    localparam logic [27:0] BASE1_DEFAULT = 28'h010_0000;

    function automatic int bursts_per_frame(input int pixels, input int ppw, input int blen);
        return pixels / (ppw * blen);
    endfunction

endpackage

// File: rtl/cfw_sync_fifo.sv
// cfw_sync_fifo: synchronous first-word-fall-through FIFO with flush; push while full is accepted when a pop frees a slot
module cfw_sync_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/capture_frame_writer.sv
// capture_frame_writer: packs captured pixels into bus words and writes them as DDR bursts into ping-pong frame buffers.
// Optional CAPTURE_FRAME_WRITER_FRAME_CNT_EN adds o_frame_cnt, a wrapping count of completed frames.
module capture_frame_writer
    import cfw_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BUS_W = 64,
    parameter int BURST_LEN = 16,
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_W = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR0 = ADDR_W'(BASE0_DEFAULT),
    parameter logic [ADDR_W-1:0] BASE_ADDR1 = ADDR_W'(BASE1_DEFAULT),
    parameter int FIFO_DEPTH = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_capture_image_vld,
    input  logic              i_capture_image_clr,
    input  logic [DATA_W-1:0] i_capture_image_data,
    output logic              o_wr_req,
    input  logic              i_wr_ack,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [BUS_W-1:0]  o_wr_data,
    input  logic              i_wr_data_rd,
    output logic              o_frame_done,
    output logic              o_rd_buf_sel,
    output logic              o_overflow
`ifdef CAPTURE_FRAME_WRITER_FRAME_CNT_EN
    ,
    output logic [15:0]       o_frame_cnt
`endif
);
    localparam int PPW = BUS_W / DATA_W;
    localparam int BPF = bursts_per_frame(FRAME_PIXELS, PPW, BURST_LEN);
    localparam int BURST_BYTES = BURST_LEN * BUS_W / 8;
    localparam int PW = $clog2(FRAME_PIXELS + 1);
    localparam int BW = $clog2(BPF + 1);
    localparam int KW = $clog2(PPW + 1);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);

    cfw_state_e       state, nxt;
    logic             frame_active, abort_pend, wr_buf_sel;
    logic [PW-1:0]    pix_cnt;
    logic [KW-1:0]    pack_idx;
    logic [BUS_W-1:0] pack_buf, pack_nxt, word_q;
    logic             push_q;
    logic [BW-1:0]    burst_idx;
    logic [CW-1:0]    pop_cnt;
    logic [FAW:0]     fifo_count;
    logic             fifo_full, fifo_empty;
    logic             last_pix, pix_ok, pop, burst_end, flush, ovf_evt;

    assign last_pix  = pack_idx == KW'(PPW - 1);
    assign pix_ok    = i_capture_image_vld && frame_active && !abort_pend && !i_capture_image_clr
                       && pix_cnt < PW'(FRAME_PIXELS);
    assign pop       = state == DATA && i_wr_data_rd && !fifo_empty;
    assign burst_end = pop && pop_cnt == CW'(BURST_LEN - 1);
    assign flush     = state == FLUSH;
    // A completed word meeting a full FIFO is lost unless a pop frees a slot in the same cycle
    assign ovf_evt   = (push_q && fifo_full && !pop && !flush) || (i_capture_image_vld && abort_pend);
    assign o_wr_addr = (wr_buf_sel ? BASE_ADDR1 : BASE_ADDR0) + ADDR_W'(burst_idx) * ADDR_W'(BURST_BYTES);

    always_comb begin
        pack_nxt = pack_buf;
        pack_nxt[pack_idx*DATA_W +: DATA_W] = i_capture_image_data;
    end

    cfw_sync_fifo #(.W(BUS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push_q),
        .din     (word_q),
        .pop     (pop),
        .flush   (flush),
        .dout    (o_wr_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            frame_active <= 1'b0;
            abort_pend   <= 1'b0;
            pix_cnt      <= '0;
            pack_idx     <= '0;
            pack_buf     <= '0;
            word_q       <= '0;
            push_q       <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            push_q <= pix_ok && last_pix;
            if (pix_ok) begin
                pix_cnt  <= pix_cnt + 1'b1;
                pack_buf <= pack_nxt;
                pack_idx <= last_pix ? '0 : pack_idx + 1'b1;
                if (last_pix) word_q <= pack_nxt;
            end
            if (ovf_evt) o_overflow <= 1'b1;
            if (flush) begin
                pack_idx   <= '0;
                abort_pend <= 1'b0;
            end
            // A start-of-frame on a frame still in flight must drain its burst and flush before reuse
            if (i_capture_image_clr) begin
                frame_active <= i_enable;
                pix_cnt      <= '0;
                if (i_enable) o_overflow <= 1'b0;
                if (frame_active && state != DONE) abort_pend <= 1'b1;
            end else if (state == DONE) begin
                frame_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            burst_idx    <= '0;
            pop_cnt      <= '0;
            wr_buf_sel   <= 1'b0;
            o_rd_buf_sel <= 1'b1;
        end else begin
            state <= nxt;
            if (pop) pop_cnt <= burst_end ? '0 : pop_cnt + 1'b1;
            if (burst_end) burst_idx <= burst_idx + 1'b1;
            if (state == DONE || flush) burst_idx <= '0;
            if (state == DONE) begin
                o_rd_buf_sel <= wr_buf_sel;
                wr_buf_sel   <= ~wr_buf_sel;
            end
        end
    end

`ifdef CAPTURE_FRAME_WRITER_FRAME_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_frame_cnt <= '0;
        else if (state == DONE) o_frame_cnt <= o_frame_cnt + 1'b1;
    end
`endif

    always_comb begin
        nxt          = state;
        o_wr_req     = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            IDLE:  nxt = abort_pend ? FLUSH : (fifo_count >= (FAW+1)'(BURST_LEN) ? REQ : IDLE);
            REQ: begin
                o_wr_req = 1'b1;
                if (i_wr_ack) nxt = DATA;
            end
            DATA:  if (burst_end) nxt = abort_pend ? FLUSH : (burst_idx == BW'(BPF - 1) ? DONE : IDLE);
            DONE: begin
                o_frame_done = 1'b1;
                nxt          = IDLE;
            end
            FLUSH: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_capture_frame_writer.sv
// tb_capture_frame_writer: randomized frames against a pixel-queue reference model of bursts, addresses and buffer flips
module tb_capture_frame_writer;
    localparam int DW = 8;
    localparam int BUSW = 64;
    localparam int BL = 4;
    localparam int FP = 1024;
    localparam int AW = 28;
    localparam int PPW = BUSW / DW;
    localparam int NB = FP / (PPW * BL);
    localparam int BB = BL * BUSW / 8;
    localparam logic [AW-1:0] B0 = 28'h000_0000;
    localparam logic [AW-1:0] B1 = 28'h010_0000;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_enable;
    logic            i_capture_image_vld;
    logic            i_capture_image_clr;
    logic [DW-1:0]   i_capture_image_data;
    logic            o_wr_req;
    logic            i_wr_ack;
    logic [AW-1:0]   o_wr_addr;
    logic [BUSW-1:0] o_wr_data;
    logic            i_wr_data_rd;
    logic            o_frame_done;
    logic            o_rd_buf_sel;
    logic            o_overflow;
`ifdef CAPTURE_FRAME_WRITER_FRAME_CNT_EN
    logic [15:0]     o_frame_cnt;
`endif

    capture_frame_writer #(
        .DATA_W(DW), .BUS_W(BUSW), .BURST_LEN(BL), .FRAME_PIXELS(FP), .ADDR_W(AW),
        .BASE_ADDR0(B0), .BASE_ADDR1(B1), .FIFO_DEPTH(64)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_enable             (i_enable),
        .i_capture_image_vld  (i_capture_image_vld),
        .i_capture_image_clr  (i_capture_image_clr),
        .i_capture_image_data (i_capture_image_data),
        .o_wr_req             (o_wr_req),
        .i_wr_ack             (i_wr_ack),
        .o_wr_addr            (o_wr_addr),
        .o_wr_data            (o_wr_data),
        .i_wr_data_rd         (i_wr_data_rd),
        .o_frame_done         (o_frame_done),
        .o_rd_buf_sel         (o_rd_buf_sel),
        .o_overflow           (o_overflow)
`ifdef CAPTURE_FRAME_WRITER_FRAME_CNT_EN
        ,
        .o_frame_cnt          (o_frame_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    bit ddr_en = 1'b1;
    logic [AW-1:0]   got_addr[$];
    logic [BUSW-1:0] got_words[$];
    logic [DW-1:0]   pix[$];
    logic exp_buf = 1'b0;
    logic exp_rd = 1'b1;
    int   exp_frames = 0;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // DDR model: ack three cycles after a request, then pop one word per cycle
    initial begin
        i_wr_ack = 1'b0;
        i_wr_data_rd = 1'b0;
        forever begin
            step();
            if (o_wr_req === 1'b1 && ddr_en) begin
                got_addr.push_back(o_wr_addr);
                repeat (2) step();
                i_wr_ack = 1'b1;
                step();
                i_wr_ack = 1'b0;
                for (int k = 0; k < BL; k++) begin
                    i_wr_data_rd = 1'b1;
                    got_words.push_back(o_wr_data);
                    step();
                end
                i_wr_data_rd = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            step();
            if (o_frame_done === 1'b1) done_cnt++;
            if (o_wr_req === 1'b1) req_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, required to finish earlier");
        $fatal(1);
    end

    function automatic logic [BUSW-1:0] exp_word(input int j);
        logic [BUSW-1:0] w;
        w = '0;
        for (int k = 0; k < PPW; k++) w[k*DW +: DW] = pix[j*PPW + k];
        return w;
    endfunction

    function automatic logic [AW-1:0] base_of(input logic s);
        return s ? B1 : B0;
    endfunction

    task automatic pulse_clr(input logic en);
        i_enable = en;
        i_capture_image_clr = 1'b1;
        step();
        i_capture_image_clr = 1'b0;
    endtask

    task automatic send_pixels(input int n, input bit ramp, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) while ($urandom_range(3) == 0) step();
            i_capture_image_data = ramp ? DW'(i) : DW'($urandom);
            pix.push_back(i_capture_image_data);
            i_capture_image_vld = 1'b1;
            step();
            i_capture_image_vld = 1'b0;
        end
    endtask

    task automatic run_frame(input bit do_clr, input bit ramp);
        int d0;
        int t;
        d0 = done_cnt;
        if (do_clr) begin
            got_addr.delete();
            got_words.delete();
            pulse_clr(1'b1);
        end
        pix.delete();
        send_pixels(FP, ramp, 1'b1);
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            step();
            t++;
        end
        n_cmp++;
        if (done_cnt == d0) begin
            n_bad++;
            $display("FAIL frame_done_timeout: no o_frame_done pulse, required one within 3000 cycles");
        end
        repeat (3) step();
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL frame_done_pulses: got %0d cycles high, required 1", done_cnt - d0);
        end
        n_cmp++;
        if (got_addr.size() != NB) begin
            n_bad++;
            $display("FAIL burst_count: got %0d bursts, required %0d", got_addr.size(), NB);
        end
        for (int b = 0; b < got_addr.size() && b < NB; b++) begin
            n_cmp++;
            if (got_addr[b] !== base_of(exp_buf) + AW'(b * BB)) begin
                n_bad++;
                $display("FAIL burst_addr[%0d]: got %h, required %h", b, got_addr[b], base_of(exp_buf) + AW'(b * BB));
            end
        end
        n_cmp++;
        if (got_words.size() != NB * BL) begin
            n_bad++;
            $display("FAIL word_count: got %0d words, required %0d", got_words.size(), NB * BL);
        end
        for (int j = 0; j < got_words.size() && j < NB * BL; j++) begin
            n_cmp++;
            if (got_words[j] !== exp_word(j)) begin
                n_bad++;
                $display("FAIL wr_data[%0d]: got %h, required %h", j, got_words[j], exp_word(j));
            end
        end
        exp_rd = exp_buf;
        exp_buf = ~exp_buf;
        exp_frames++;
        n_cmp++;
        if (o_rd_buf_sel !== exp_rd) begin
            n_bad++;
            $display("FAIL rd_buf_sel: got %b, required %b", o_rd_buf_sel, exp_rd);
        end
`ifdef CAPTURE_FRAME_WRITER_FRAME_CNT_EN
        n_cmp++;
        if (o_frame_cnt !== 16'(exp_frames)) begin
            n_bad++;
            $display("FAIL frame_cnt: got %0d, required %0d", o_frame_cnt, exp_frames);
        end
`endif
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_enable = 1'b0;
        i_capture_image_vld = 1'b0;
        i_capture_image_clr = 1'b0;
        i_capture_image_data = '0;
        repeat (3) step();
        i_rst_n = 1'b1;
        step();
        n_cmp++;
        if (o_wr_req !== 1'b0) begin n_bad++; $display("FAIL reset_wr_req: got %b, required 0", o_wr_req); end
        n_cmp++;
        if (o_wr_addr !== '0) begin n_bad++; $display("FAIL reset_wr_addr: got %h, required 0", o_wr_addr); end
        n_cmp++;
        if (o_frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b, required 0", o_frame_done); end
        n_cmp++;
        if (o_rd_buf_sel !== 1'b1) begin n_bad++; $display("FAIL reset_rd_buf_sel: got %b, required 1", o_rd_buf_sel); end
        n_cmp++;
        if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b, required 0", o_overflow); end
`ifdef CAPTURE_FRAME_WRITER_FRAME_CNT_EN
        n_cmp++;
        if (o_frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d, required 0", o_frame_cnt); end
`endif
    endtask

    task automatic test_full_frame();
        run_frame(1'b1, 1'b1);
        n_cmp++;
        if (got_words.size() == 0 || got_words[0] !== 64'h0706050403020100) begin
            n_bad++;
            $display("FAIL first_word: got %h, required 0706050403020100", got_words.size() ? got_words[0] : 'x);
        end
        n_cmp++;
        if (got_addr.size() != NB || got_addr[NB-1] !== 28'h00003E0) begin
            n_bad++;
            $display("FAIL last_addr: got %h, required 00003e0", got_addr.size() ? got_addr[got_addr.size()-1] : 'x);
        end
        n_cmp++;
        if (o_rd_buf_sel !== 1'b0) begin n_bad++; $display("FAIL first_rd_buf_sel: got %b, required 0", o_rd_buf_sel); end
    endtask

    task automatic test_back_to_back();
        run_frame(1'b1, 1'b0);
        n_cmp++;
        if (got_addr.size() == 0 || got_addr[0] !== 28'h0100000) begin
            n_bad++;
            $display("FAIL second_base: got %h, required 0100000", got_addr.size() ? got_addr[0] : 'x);
        end
        n_cmp++;
        if (o_rd_buf_sel !== 1'b1) begin n_bad++; $display("FAIL second_rd_buf_sel: got %b, required 1", o_rd_buf_sel); end
        run_frame(1'b1, 1'b0);
        n_cmp++;
        if (got_addr.size() == 0 || got_addr[0] !== 28'h0000000) begin
            n_bad++;
            $display("FAIL third_base: got %h, required 0000000", got_addr.size() ? got_addr[0] : 'x);
        end
    endtask

    task automatic test_short_frame();
        int d0;
        d0 = done_cnt;
        pulse_clr(1'b1);
        send_pixels(500, 1'b0, 1'b1);
        pulse_clr(1'b1);
        repeat (40) step();
        n_cmp++;
        if (done_cnt != d0) begin n_bad++; $display("FAIL short_frame_done: got %0d pulses, required 0", done_cnt - d0); end
        n_cmp++;
        if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL short_frame_overflow: got %b, required 0", o_overflow); end
`ifdef CAPTURE_FRAME_WRITER_FRAME_CNT_EN
        n_cmp++;
        if (o_frame_cnt !== 16'(exp_frames)) begin
            n_bad++;
            $display("FAIL aborted_frame_cnt: got %0d, required %0d", o_frame_cnt, exp_frames);
        end
`endif
        got_addr.delete();
        got_words.delete();
        run_frame(1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        ddr_en = 1'b0;
        got_addr.delete();
        got_words.delete();
        pulse_clr(1'b1);
        pix.delete();
        send_pixels(FP, 1'b0, 1'b0);
        repeat (4) step();
        n_cmp++;
        if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_set: got %b, required 1", o_overflow); end
        n_cmp++;
        if (o_wr_req !== 1'b1) begin n_bad++; $display("FAIL overflow_req_held: got %b, required 1", o_wr_req); end
        pulse_clr(1'b1);
        n_cmp++;
        if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL overflow_cleared: got %b, required 0", o_overflow); end
        ddr_en = 1'b1;
        repeat (40) step();
        n_cmp++;
        if (got_addr.size() != 1 || got_addr[0] !== base_of(exp_buf)) begin
            n_bad++;
            $display("FAIL drain_burst: got %0d bursts, required 1 at %h", got_addr.size(), base_of(exp_buf));
        end
        for (int j = 0; j < got_words.size() && j < BL; j++) begin
            n_cmp++;
            if (got_words[j] !== exp_word(j)) begin
                n_bad++;
                $display("FAIL drain_data[%0d]: got %h, required %h", j, got_words[j], exp_word(j));
            end
        end
        n_cmp++;
        if (o_wr_req !== 1'b0 || o_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL after_flush: got req=%b ovf=%b, required req=0 ovf=0", o_wr_req, o_overflow);
        end
    endtask

    task automatic test_disabled();
        int d0;
        int r0;
        pulse_clr(1'b0);
        repeat (10) step();
        got_addr.delete();
        got_words.delete();
        d0 = done_cnt;
        r0 = req_cnt;
        pix.delete();
        send_pixels(FP, 1'b0, 1'b0);
        repeat (50) step();
        n_cmp++;
        if (req_cnt != r0 || got_addr.size() != 0) begin
            n_bad++;
            $display("FAIL disabled_req: got %0d req cycles, required 0", req_cnt - r0);
        end
        n_cmp++;
        if (done_cnt != d0) begin n_bad++; $display("FAIL disabled_done: got %0d pulses, required 0", done_cnt - d0); end
        n_cmp++;
        if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL disabled_overflow: got %b, required 0", o_overflow); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_short_frame();
        test_overflow();
        test_disabled();
        run_frame(1'b1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
